tiled_matmul_engine: RTL and testbench

TILED_MATMUL_ENGINE -- requirements
Module: tiled_matmul_engine

---
 rtl/npu_mm_pkg.sv | 29 ++
 rtl/mm_tile_array.sv | 57 +++++
 rtl/tiled_matmul_engine.sv | 158 +++++++++++++++
 tb/tb_tiled_matmul_engine.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_mm_pkg.sv
// Shared types, default sizes and derived-width helpers for the tiled matrix-multiply engine.
package npu_mm_pkg;

    localparam int DIM_DEF    = 16;
    localparam int TILE_DEF   = 8;
    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 32;

    localparam int TILE_LAT = 3 * TILE_DEF - 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    function automatic int tile_lat(input int tile);
        return 3 * tile - 1;
    endfunction

    // Tile dot products are kept exact so the accumulator add can see every overflow.
    function automatic int tile_sum_w(input int tile, input int data_w, input int acc_w);
        int need;
        need = 2 * data_w + $clog2(tile) + 1;
        return (need > acc_w) ? need : acc_w;
    endfunction

endpackage

// File: rtl/mm_tile_array.sv
// One TILE x TILE block product; the result is captured on valid-in and valid-out follows
// exactly tile_lat(TILE) cycles later.
module mm_tile_array
    import npu_mm_pkg::*;
#(
    parameter int TILE   = TILE_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    localparam int SUM_W = tile_sum_w(TILE, DATA_W, ACC_W)
) (
    input  logic                              i_clk,
    input  logic                              i_arst,
    input  logic                              i_valid,
    input  logic signed [DATA_W-1:0]          i_a [TILE][TILE],
    input  logic signed [DATA_W-1:0]          i_b [TILE][TILE],
    output logic                              o_valid,
    output logic [TILE*TILE-1:0][SUM_W-1:0]   o_c
);

    localparam int LAT = tile_lat(TILE);

    logic [LAT-1:0]                  vld_sr;
    logic [TILE*TILE-1:0][SUM_W-1:0] dot;

    always_comb begin
        logic signed [SUM_W-1:0] sum;
        logic signed [SUM_W-1:0] pa;
        logic signed [SUM_W-1:0] pb;
        dot = '0;
        for (int i = 0; i < TILE; i++) begin
            for (int j = 0; j < TILE; j++) begin
                sum = '0;
                for (int m = 0; m < TILE; m++) begin
                    pa  = {{(SUM_W-DATA_W){i_a[i][m][DATA_W-1]}}, i_a[i][m]};
                    pb  = {{(SUM_W-DATA_W){i_b[m][j][DATA_W-1]}}, i_b[m][j]};
                    sum = sum + pa * pb;
                end
                dot[i*TILE+j] = sum;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            vld_sr <= '0;
            o_c    <= '0;
        end else begin
            vld_sr <= {vld_sr[LAT-2:0], i_valid};
            if (i_valid) begin
                o_c <= dot;
            end
        end
    end

    assign o_valid = vld_sr[LAT-1];

endmodule

// File: rtl/tiled_matmul_engine.sv
// DIM x DIM signed matrix multiply built from T x T tile arrays, stepping the shared
// dimension one tile block per phase and accumulating into a wrapping result register.
module tiled_matmul_engine
    import npu_mm_pkg::*;
#(
    parameter int DIM    = DIM_DEF,
    parameter int TILE   = TILE_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_arst,
    input  logic signed [DATA_W-1:0] i_a [DIM][DIM],
    input  logic signed [DATA_W-1:0] i_b [DIM][DIM],
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic                     i_accumulate,
    output logic signed [ACC_W-1:0]  o_c [DIM][DIM],
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic                     o_overflow
);

    localparam int T     = DIM / TILE;
    localparam int SUM_W = tile_sum_w(TILE, DATA_W, ACC_W);
    localparam int KW    = (T > 1) ? $clog2(T) : 1;

    if ((DIM % TILE) != 0 || TILE < 2) begin : g_bad_cfg
        $fatal(1, "tiled_matmul_engine: DIM must be a multiple of TILE and TILE >= 2");
    end

    state_t                          state_q, state_d;
    logic [KW-1:0]                   k_q;
    logic signed [DATA_W-1:0]        a_q [DIM][DIM];
    logic signed [DATA_W-1:0]        b_q [DIM][DIM];
    logic signed [ACC_W-1:0]         acc_q   [DIM][DIM];
    logic signed [ACC_W-1:0]         acc_sum [DIM][DIM];
    logic                            add_ovf;
    logic                            ovf_q;
    logic [T*T-1:0]                  tile_vld;
    logic [T*T-1:0][TILE*TILE-1:0][SUM_W-1:0] tile_c;
    logic                            accept, all_vld, last_k, tile_issue;

    assign accept     = i_valid && (state_q == IDLE);
    assign all_vld    = &tile_vld;
    assign last_k     = (int'(k_q) == T - 1);
    assign tile_issue = (state_q == ISSUE);

    always_comb begin
        state_d = state_q;
        o_ready = 1'b0;
        o_valid = 1'b0;
        case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (accept) state_d = ISSUE;
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (all_vld) state_d = last_k ? DONE : ISSUE;
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state_q <= IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                k_q <= '0;
            end else if (state_q == WAIT && all_vld && !last_k) begin
                k_q <= k_q + 1'b1;
            end
        end
    end

    // Operands are held for the whole transaction; the request inputs are free after accept.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            a_q <= i_a;
            b_q <= i_b;
        end
    end

    for (genvar gr = 0; gr < T; gr++) begin : g_row
        for (genvar gc = 0; gc < T; gc++) begin : g_col
            logic signed [DATA_W-1:0] blk_a [TILE][TILE];
            logic signed [DATA_W-1:0] blk_b [TILE][TILE];

            always_comb begin
                for (int i = 0; i < TILE; i++) begin
                    for (int j = 0; j < TILE; j++) begin
                        blk_a[i][j] = a_q[gr*TILE+i][int'(k_q)*TILE+j];
                        blk_b[i][j] = b_q[int'(k_q)*TILE+i][gc*TILE+j];
                    end
                end
            end

            mm_tile_array #(
                .TILE   (TILE),
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_tile (
                .i_clk   (i_clk),
                .i_arst  (i_arst),
                .i_valid (tile_issue),
                .i_a     (blk_a),
                .i_b     (blk_b),
                .o_valid (tile_vld[gr*T+gc]),
                .o_c     (tile_c[gr*T+gc])
            );
        end
    end

    // Exact sum in SUM_W+1 bits; overflow when it no longer sign-fits in ACC_W.
    always_comb begin
        logic [SUM_W-1:0] elem;
        logic [SUM_W:0]   wide;
        add_ovf = 1'b0;
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                elem = tile_c[(r/TILE)*T + (c/TILE)][(r%TILE)*TILE + (c%TILE)];
                wide = {{(SUM_W+1-ACC_W){acc_q[r][c][ACC_W-1]}}, acc_q[r][c]}
                     + {elem[SUM_W-1], elem};
                acc_sum[r][c] = wide[ACC_W-1:0];
                if (!((&wide[SUM_W:ACC_W-1]) || !(|wide[SUM_W:ACC_W-1]))) begin
                    add_ovf = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            acc_q <= '{default: '0};
            ovf_q <= 1'b0;
        end else if (accept) begin
            if (!i_accumulate) begin
                acc_q <= '{default: '0};
                ovf_q <= 1'b0;
            end
        end else if (state_q == WAIT && all_vld) begin
            acc_q <= acc_sum;
            if (add_ovf) ovf_q <= 1'b1;
        end
    end

    assign o_c        = acc_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_tiled_matmul_engine.sv
// Directed and random requests against a plain-arithmetic block-phase model of C = A x B,
// plus a narrow-accumulator instance for wrap and overflow.
module tb_tiled_matmul_engine;

    localparam int DIM     = 16;
    localparam int TILE    = 8;
    localparam int DW      = 8;
    localparam int AW      = 32;
    localparam int T       = DIM / TILE;
    localparam int LAT     = 3 * TILE - 1;
    localparam int EXP_LAT = T * (LAT + 1) + 1;

    logic clk = 1'b0;
    logic arst;
    logic signed [DW-1:0] a [DIM][DIM];
    logic signed [DW-1:0] b [DIM][DIM];
    logic valid, ready_out, accum, ovalid, iready, ovf;
    logic signed [AW-1:0] c [DIM][DIM];

    logic valid16, ready16, ovalid16, ovf16;
    logic signed [15:0] c16 [DIM][DIM];

    int vectors = 0;
    int miscompares = 0;

    longint mdl [DIM][DIM];
    bit     mdl_ovf;

    always #5 clk = ~clk;

    tiled_matmul_engine #(.DIM(DIM), .TILE(TILE), .DATA_W(DW), .ACC_W(AW)) dut (
        .i_clk(clk), .i_arst(arst), .i_a(a), .i_b(b), .i_valid(valid), .o_ready(ready_out),
        .i_accumulate(accum), .o_c(c), .o_valid(ovalid), .i_ready(iready), .o_overflow(ovf)
    );

    tiled_matmul_engine #(.DIM(DIM), .TILE(TILE), .DATA_W(DW), .ACC_W(16)) dut16 (
        .i_clk(clk), .i_arst(arst), .i_a(a), .i_b(b), .i_valid(valid16), .o_ready(ready16),
        .i_accumulate(1'b0), .o_c(c16), .o_valid(ovalid16), .i_ready(1'b1), .o_overflow(ovf16)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_mat(input string tag);
        int bad, br, bc;
        bad = 0; br = 0; bc = 0;
        for (int r = 0; r < DIM; r++)
            for (int cc = 0; cc < DIM; cc++)
                if (longint'(c[r][cc]) !== mdl[r][cc]) begin
                    if (bad == 0) begin br = r; bc = cc; end
                    bad++;
                end
        vectors++;
        assert (bad === 0) else begin
            miscompares++;
            $error("FAIL %s: %0d bad elements, c[%0d][%0d] observed %0d expected %0d",
                   tag, bad, br, bc, c[br][bc], mdl[br][bc]);
        end
    endtask

    // C accumulates one k-block of the shared dimension at a time, wrapping to AW bits.
    task automatic model_accept(input bit acc_mode);
        longint part, s, m;
        m = longint'(1) << AW;
        if (!acc_mode) begin
            for (int r = 0; r < DIM; r++)
                for (int cc = 0; cc < DIM; cc++) mdl[r][cc] = 0;
            mdl_ovf = 0;
        end
        for (int r = 0; r < DIM; r++)
            for (int cc = 0; cc < DIM; cc++)
                for (int kk = 0; kk < T; kk++) begin
                    part = 0;
                    for (int x = kk * TILE; x < (kk + 1) * TILE; x++)
                        part += longint'(a[r][x]) * longint'(b[x][cc]);
                    s = mdl[r][cc] + part;
                    if (s >= m / 2 || s < -(m / 2)) begin
                        mdl_ovf = 1;
                        s = ((s % m) + m) % m;
                        if (s >= m / 2) s -= m;
                    end
                    mdl[r][cc] = s;
                end
    endtask

    task automatic model_clear();
        for (int r = 0; r < DIM; r++)
            for (int cc = 0; cc < DIM; cc++) mdl[r][cc] = 0;
        mdl_ovf = 0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (ovalid !== 1'b1 && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic accept_req(input bit acc_mode);
        valid = 1'b1;
        accum = acc_mode;
        @(posedge clk); #1;
        valid = 1'b0;
        model_accept(acc_mode);
    endtask

    task automatic run_req(input string tag, input bit acc_mode);
        int cyc;
        accept_req(acc_mode);
        wait_done(cyc);
        chk({tag, "_latency"}, cyc, EXP_LAT);
        chk_mat({tag, "_c"});
        chk({tag, "_ovf"}, ovf, mdl_ovf);
        @(posedge clk); #1;
        chk({tag, "_ready_after"}, ready_out, 1);
        chk({tag, "_valid_after"}, ovalid, 0);
    endtask

    task automatic load_ident_b();
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                a[i][j] = (i == j) ? 8'sd1 : 8'sd0;
                b[i][j] = DW'(i + j);
            end
    endtask

    task automatic load_const(input int av, input int bv);
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                a[i][j] = DW'(av);
                b[i][j] = DW'(bv);
            end
    endtask

    initial begin
        int cyc, seen, bad16;
        arst = 1'b1; valid = 1'b0; valid16 = 1'b0; accum = 1'b0; iready = 1'b1;
        load_const(0, 0);
        model_clear();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ready_out, 1);
        chk("rst_valid", ovalid, 0);
        chk("rst_ovf", ovf, 0);
        chk_mat("rst_c");
        arst = 1'b0;
        @(posedge clk); #1;

        load_ident_b();
        run_req("ident", 1'b0);
        chk("ident_c_21", c[2][1], 3);

        load_const(-128, -128);
        run_req("neg128", 1'b0);
        chk("neg128_c_57", c[5][7], 262144);

        load_const(1, 1);
        run_req("ones", 1'b0);
        chk("ones_c_39", c[3][9], 16);
        run_req("ones_acc", 1'b1);
        chk("ones_acc_c_39", c[3][9], 32);

        // Consumer stalls in DONE while extra requests are offered.
        load_ident_b();
        iready = 1'b0;
        accept_req(1'b0);
        wait_done(cyc);
        chk("stall_latency", cyc, EXP_LAT);
        for (int n = 0; n < 5; n++) begin
            a[n][n] = DW'($urandom);
            valid = 1'b1;
            @(posedge clk); #1;
            chk("stall_valid", ovalid, 1);
            chk("stall_ready", ready_out, 0);
            chk_mat("stall_c");
        end
        valid = 1'b0;
        iready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release_valid", ovalid, 0);
        chk("stall_release_ready", ready_out, 1);
        seen = 0;
        repeat (EXP_LAT + 10) begin
            @(posedge clk); #1;
            if (ovalid === 1'b1 || ready_out !== 1'b1) seen++;
        end
        chk("stall_extra_not_accepted", seen, 0);

        // Reset in the middle of a transaction.
        load_ident_b();
        accept_req(1'b0);
        repeat (19) @(posedge clk);
        arst = 1'b1;
        @(posedge clk); #1;
        arst = 1'b0;
        model_clear();
        chk("midrst_ready", ready_out, 1);
        chk("midrst_valid", ovalid, 0);
        chk_mat("midrst_c");
        seen = 0;
        repeat (EXP_LAT + 10) begin
            @(posedge clk); #1;
            if (ovalid === 1'b1) seen++;
        end
        chk("midrst_no_stale_valid", seen, 0);
        run_req("post_rst_ident", 1'b0);

        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < DIM; i++)
                for (int j = 0; j < DIM; j++) begin
                    a[i][j] = DW'($urandom);
                    b[i][j] = DW'($urandom);
                end
            run_req("rand", (it > 0) ? 1'($urandom_range(0, 1)) : 1'b0);
        end

        // Narrow accumulator: 16 * 127 * 127 = 258064 wraps and flags overflow.
        load_const(127, 127);
        valid16 = 1'b1;
        @(posedge clk); #1;
        valid16 = 1'b0;
        cyc = 1;
        while (ovalid16 !== 1'b1 && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("acc16_latency", cyc, EXP_LAT);
        chk("acc16_ovf", ovf16, 1);
        bad16 = 0;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++)
                if (c16[i][j] !== 16'(258064)) bad16++;
        chk("acc16_bad_elems", bad16, 0);
        chk("acc16_c_00", c16[0][0], -4080);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
